input_fifo: RTL and testbench

INPUT_FIFO -- requirements
Module: input_fifo

---
 rtl/noc_pkg.sv | 11 +
 rtl/fifo_ctrl.sv | 63 ++++++
 rtl/input_fifo.sv | 61 ++++++
 tb/tb_input_fifo.sv | 185 ++++++++++++++++++
 4 files changed

// File: rtl/noc_pkg.sv
// Shared NoC router constants: flit width, input-buffer depth and pointer width.
// Used by the input FIFO and the arbiter stage.
package noc_pkg;

  localparam int DATA_WIDTH = 32;
  localparam int DEPTH      = 4;
  localparam int PTR_W      = $clog2(DEPTH);

  typedef logic [DATA_WIDTH-1:0] flit_t;

endpackage

// File: rtl/fifo_ctrl.sv
// Pointer and occupancy bookkeeping for the router input FIFO.
// Gates the write and read requests against the full and empty flags.
module fifo_ctrl #(
  parameter  int DEPTH = noc_pkg::DEPTH,
  localparam int PW    = $clog2(DEPTH),
  localparam int CW    = PW + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          wr_req,
  input  logic          rd_req,
  output logic          wr_en,
  output logic [PW-1:0] wr_ptr,
  output logic [PW-1:0] rd_ptr,
  output logic          empty,
  output logic          full
);

  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          rd_en;

  assign empty  = (count_q == '0);
  assign full   = (count_q == FULL_CNT);
  assign wr_ptr = wr_ptr_q;
  assign rd_ptr = rd_ptr_q;

  // No bypass: a write is refused while full even if the same edge pops.
  assign wr_en = wr_req && !full;
  assign rd_en = rd_req && !empty;

  always_comb begin
    // NOTE: every always_comb output gets a default first so no latch is inferred.
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    // Pointers are PW bits wide, so DEPTH being a power of two makes +1 wrap naturally.
    if (wr_en) wr_ptr_d = wr_ptr_q + 1'b1;
    if (rd_en) rd_ptr_d = rd_ptr_q + 1'b1;
    unique case ({wr_en, rd_en})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: rtl/input_fifo.sv
// Router input buffer: CTS/DRTS handshake on the write side, fall-through head flit
// popped by any of the five output-port arbiter grants.
module input_fifo #(
  parameter  int DATA_WIDTH = noc_pkg::DATA_WIDTH,
  parameter  int DEPTH      = noc_pkg::DEPTH,
  localparam int PW         = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] RX,
  input  logic                  DRTS,
  input  logic                  read_en_N,
  input  logic                  read_en_E,
  input  logic                  read_en_W,
  input  logic                  read_en_S,
  input  logic                  read_en_L,
  output logic                  CTS,
  output logic [DATA_WIDTH-1:0] Data_out,
  output logic                  empty_out,
  output logic                  full_out
);

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic                  cts_q, cts_d;
  logic                  wr_req, rd_req, wr_en;
  logic [PW-1:0]         wr_ptr, rd_ptr;

  // CTS high blocks the next write, which caps the link at one flit every two cycles.
  assign wr_req = DRTS && !cts_q;
  assign rd_req = read_en_N || read_en_E || read_en_W || read_en_S || read_en_L;

  fifo_ctrl #(.DEPTH(DEPTH)) u_ctrl (
    .clk    (clk),
    .rst    (rst),
    .wr_req (wr_req),
    .rd_req (rd_req),
    .wr_en  (wr_en),
    .wr_ptr (wr_ptr),
    .rd_ptr (rd_ptr),
    .empty  (empty_out),
    .full   (full_out)
  );

  always_comb begin
    cts_d = wr_en;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) cts_q <= 1'b0;
    else      cts_q <= cts_d;
  end

  // NOTE: storage has no reset; the cleared count already marks every slot invalid.
  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_ptr] <= RX;
  end

  assign CTS      = cts_q;
  assign Data_out = mem_q[rd_ptr];

endmodule

// File: tb/tb_input_fifo.sv
// Self-checking bench for input_fifo: a queue scoreboard of stored flits is updated
// as stimulus is driven and compared against the head flit and flags every cycle.
module tb_input_fifo;

  localparam int DW    = 32;
  localparam int DEPTH = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic [DW-1:0] rx;
  logic          drts;
  logic          rn, re, rw, rs, rl;
  logic          cts;
  logic [DW-1:0] data_out;
  logic          empty_out, full_out;

  int            n_checks = 0;
  int            n_errors = 0;
  logic [DW-1:0] exp_q [$];
  logic          m_cts;

  always #5 clk = ~clk;

  input_fifo #(.DATA_WIDTH(DW), .DEPTH(DEPTH)) dut (
    .clk       (clk),
    .rst       (rst),
    .RX        (rx),
    .DRTS      (drts),
    .read_en_N (rn),
    .read_en_E (re),
    .read_en_W (rw),
    .read_en_S (rs),
    .read_en_L (rl),
    .CTS       (cts),
    .Data_out  (data_out),
    .empty_out (empty_out),
    .full_out  (full_out)
  );

  task automatic check(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // One clock cycle: predict the edge from the current drive, then check after it.
  task automatic tick();
    logic wr, rd;
    wr = drts && !m_cts && (exp_q.size() < DEPTH);
    rd = (rn || re || rw || rs || rl) && (exp_q.size() != 0);
    if (rd) begin
      check("pop_head", data_out, exp_q[0]);
      void'(exp_q.pop_front());
    end
    if (wr) exp_q.push_back(rx);
    m_cts = wr;
    @(negedge clk);
    check("cts", {31'b0, cts}, {31'b0, m_cts});
    check("empty_out", {31'b0, empty_out}, {31'b0, exp_q.size() == 0});
    check("full_out", {31'b0, full_out}, {31'b0, exp_q.size() == DEPTH});
    if (exp_q.size() != 0) check("data_out", data_out, exp_q[0]);
  endtask

  task automatic send(input logic [DW-1:0] v);
    logic done;
    done = 1'b0;
    rx   = v;
    drts = 1'b1;
    for (int i = 0; i < 20 && !done; i++) begin
      tick();
      done = m_cts;
    end
    drts = 1'b0;
    check("send_accepted", {31'b0, cts}, 32'd1);
  endtask

  task automatic drain();
    rn = 1'b1;
    for (int i = 0; i < 20 && exp_q.size() != 0; i++) tick();
    rn = 1'b0;
    check("drained_empty", {31'b0, empty_out}, 32'd1);
  endtask

  initial begin
    logic [DW-1:0] next;
    rst = 1'b0; rx = '0; drts = 1'b0;
    rn = 1'b0; re = 1'b0; rw = 1'b0; rs = 1'b0; rl = 1'b0;
    m_cts = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_empty", {31'b0, empty_out}, 32'd1);
    check("rst_full", {31'b0, full_out}, 32'd0);
    check("rst_cts", {31'b0, cts}, 32'd0);
    rst = 1'b1;
    tick();

    // Basic handshake
    rx = 32'hA5A5_A5A5; drts = 1'b1;
    tick();
    drts = 1'b0;
    check("basic_cts", {31'b0, cts}, 32'd1);
    check("basic_empty", {31'b0, empty_out}, 32'd0);
    check("basic_data", data_out, 32'hA5A5_A5A5);
    tick();
    drain();

    // Full boundary: a held write waits for one pop, then lands on the following edge
    for (int i = 0; i < DEPTH; i++) send(32'h100 + DW'(i));
    check("full_set", {31'b0, full_out}, 32'd1);
    rx = 32'h5555_0005; drts = 1'b1;
    repeat (3) tick();
    check("full_hold_cts", {31'b0, cts}, 32'd0);
    re = 1'b1;
    tick();
    re = 1'b0;
    check("full_after_pop", {31'b0, full_out}, 32'd0);
    tick();
    drts = 1'b0;
    check("full_fifth_cts", {31'b0, cts}, 32'd1);
    check("full_refilled", {31'b0, full_out}, 32'd1);
    drain();

    // Multi-grant pop
    send(32'h0000_0011);
    send(32'h0000_0022);
    rn = 1'b1; rl = 1'b1;
    tick();
    rn = 1'b0; rl = 1'b0;
    check("multi_head", data_out, 32'h0000_0022);
    check("multi_not_empty", {31'b0, empty_out}, 32'd0);
    drain();

    // Empty boundary
    rs = 1'b1;
    repeat (2) tick();
    rs = 1'b0;
    check("empty_read_empty", {31'b0, empty_out}, 32'd1);
    check("empty_read_full", {31'b0, full_out}, 32'd0);
    send(32'h0000_0077);
    check("empty_read_ptrs", data_out, 32'h0000_0077);
    drain();

    // Wrap-around stream with interleaved reads
    next = 32'd1;
    for (int c = 0; c < 200 && (next <= 32'd10 || exp_q.size() != 0); c++) begin
      drts = (next <= 32'd10);
      rx   = next;
      rn   = (c % 3 == 2);
      tick();
      if (m_cts) next = next + 32'd1;
    end
    drts = 1'b0; rn = 1'b0;
    check("wrap_all_sent", next, 32'd11);
    check("wrap_empty", {31'b0, empty_out}, 32'd1);

    // Asynchronous reset mid-operation, right after an accepted write
    send(32'h1);
    send(32'h2);
    send(32'h3);
    #2 rst = 1'b0;
    #1;
    check("arst_empty", {31'b0, empty_out}, 32'd1);
    check("arst_cts", {31'b0, cts}, 32'd0);
    check("arst_full", {31'b0, full_out}, 32'd0);
    exp_q.delete();
    m_cts = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    tick();
    send(32'h0000_BEEF);
    check("arst_first_out", data_out, 32'h0000_BEEF);
    drain();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
